rvh_l1d_st_merge_buf: RTL and testbench

Parametrised store alignment and merge buffer between the LSU store pipe and the L1D store interface. It turns each XLEN-wide store (address, size, data) into a line-aligned data vector and byte mask. It then coalesces consecutive stores to the same cache line into one entry before handing the entry to L1D over a valid/ready handshake. It replaces per-store stateless mask translation and cuts L1D store-port occupancy for sequential store streams.

---
 rtl/rvh_l1d_pkg.sv | 48 ++++
 rtl/rvh_l1d_st_align.sv | 64 ++++++
 rtl/rvh_l1d_st_merge_buf.sv | 202 ++++++++++++++++++++
 tb/tb_rvh_l1d_st_merge_buf.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvh_l1d_pkg.sv
// ============================================================================
// Module   : rvh_l1d_pkg
// Purpose  : Shared types and constants for the L1D store path.
//            - L1D_OFFSET_WIDTH     : log2 of the default line size in bytes
//            - st_size_e            : store size code (B/H/W/D)
//            - rvh_l1d_st_merge_entry_t : one merge-buffer entry at default sizes
//            - st_size_bytemask()   : right-justified byte mask for a size code
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rvh_l1d_pkg;

  localparam int L1D_OFFSET_WIDTH = 6;
  localparam int L1D_LINE_BYTES   = 1 << L1D_OFFSET_WIDTH;
  localparam int L1D_PADDR_WIDTH  = 56;

  typedef enum logic [1:0] {
    ST_B = 2'd0,
    ST_H = 2'd1,
    ST_W = 2'd2,
    ST_D = 2'd3
  } st_size_e;

  typedef struct packed {
    logic [L1D_PADDR_WIDTH-L1D_OFFSET_WIDTH-1:0] line_paddr;
    logic [L1D_LINE_BYTES*8-1:0]                 data;
    logic [L1D_LINE_BYTES-1:0]                   mask;
    logic                                        open;
  } rvh_l1d_st_merge_entry_t;

  // Byte enables of a right-justified store of the given size.
  function automatic logic [7:0] st_size_bytemask(input st_size_e sz);
    logic [7:0] m;
    m = 8'h01;
    case (sz)
      ST_B: m = 8'h01;
      ST_H: m = 8'h03;
      ST_W: m = 8'h0F;
      ST_D: m = 8'hFF;
      default: m = 8'h01;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rvh_l1d_st_align.sv
// ============================================================================
// Module   : rvh_l1d_st_align
// Purpose  : Combinational store aligner. Places a right-justified store into
//            its byte lane within a cache line and flags misalignment.
// Ports    : i_offset   - byte offset within the line
//            i_size     - size code (B/H/W/D)
//            i_data     - right-justified store data
//            o_data     - line-wide data, zero outside the written bytes
//            o_mask     - line-wide byte enables
//            o_misalign - offset not a multiple of the size, or D on XLEN=32
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvh_l1d_st_align
  import rvh_l1d_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int LINE_BYTES = 64
) (
  input  logic [$clog2(LINE_BYTES)-1:0] i_offset,
  input  logic [1:0]                    i_size,
  input  logic [XLEN-1:0]               i_data,
  output logic [LINE_BYTES*8-1:0]       o_data,
  output logic [LINE_BYTES-1:0]         o_mask,
  output logic                          o_misalign
);

  localparam int DATA_W = LINE_BYTES * 8;

  st_size_e    w_size;
  logic [7:0]  w_size_mask;
  logic [63:0] w_data64;
  logic [63:0] w_trim;

  assign w_size      = st_size_e'(i_size);
  assign w_size_mask = st_size_bytemask(w_size);
  assign w_data64    = 64'(i_data);

  // Zero the bytes above the store size so stale upper data never leaks.
  always_comb begin
    w_trim = '0;
    for (int b = 0; b < 8; b++) begin
      w_trim[b*8 +: 8] = w_size_mask[b] ? w_data64[b*8 +: 8] : 8'h00;
    end
  end

  assign o_mask = LINE_BYTES'(w_size_mask) << i_offset;
  assign o_data = DATA_W'(w_trim) << {i_offset, 3'b000};

  always_comb begin
    o_misalign = 1'b0;
    case (w_size)
      ST_B: o_misalign = 1'b0;
      ST_H: o_misalign = i_offset[0];
      ST_W: o_misalign = |i_offset[1:0];
      ST_D: o_misalign = (|i_offset[2:0]) || (XLEN == 32);
      default: o_misalign = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rvh_l1d_st_merge_buf.sv
// ============================================================================
// Module   : rvh_l1d_st_merge_buf
// Purpose  : Store alignment and merge buffer between the LSU store pipe and
//            the L1D store port. Stores are aligned to line data + byte mask,
//            consecutive stores to the same line coalesce into the youngest
//            (open) entry, and closed entries drain in order to L1D.
// Macro    : RVH_L1D_ST_MERGE_EN - enables merging, idle counter and timeout.
//            Without it every store becomes its own closed entry.
// Ports    : st_req_*   - store request (valid/ready, paddr, size, data)
//            flush_i    - close the open entry
//            l1d_st_*   - head entry to L1D (valid/ready, line, data, mask)
//            misalign_err_o - pulse: accepted store dropped as misaligned
//            empty_o    - no valid entries
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvh_l1d_st_merge_buf
  import rvh_l1d_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int LINE_BYTES = L1D_LINE_BYTES,
  parameter int PADDR_W    = 56,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      st_req_vld_i,
  output logic                                      st_req_rdy_o,
  input  logic [PADDR_W-1:0]                        st_req_paddr_i,
  input  logic [1:0]                                st_req_size_i,
  input  logic [XLEN-1:0]                           st_req_data_i,
  input  logic                                      flush_i,
  output logic                                      l1d_st_vld_o,
  input  logic                                      l1d_st_rdy_i,
  output logic [PADDR_W-$clog2(LINE_BYTES)-1:0]     l1d_st_line_paddr_o,
  output logic [LINE_BYTES*8-1:0]                   l1d_st_data_o,
  output logic [LINE_BYTES-1:0]                     l1d_st_byte_mask_o,
  output logic                                      misalign_err_o,
  output logic                                      empty_o
);

  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int LINE_W   = PADDR_W - OFFSET_W;
  localparam int DATA_W   = LINE_BYTES * 8;
  localparam int PTR_W    = $clog2(DEPTH);

  logic               r_vld  [DEPTH];
  logic               r_open [DEPTH];
  logic [LINE_W-1:0]  r_line [DEPTH];
  logic [DATA_W-1:0]  r_data [DEPTH];
  logic [LINE_BYTES-1:0] r_mask [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [PTR_W:0]     r_count;
  logic               r_misalign;

  logic [OFFSET_W-1:0]   w_offset;
  logic [LINE_W-1:0]     w_line_in;
  logic [DATA_W-1:0]     w_al_data;
  logic [LINE_BYTES-1:0] w_al_mask;
  logic                  w_mis;
  logic                  w_acc;
  logic                  w_store;
  logic                  w_hit;
  logic                  w_alloc;
  logic                  w_deq;
  logic                  w_alloc_open;

  assign w_offset  = st_req_paddr_i[OFFSET_W-1:0];
  assign w_line_in = st_req_paddr_i[PADDR_W-1:OFFSET_W];

  rvh_l1d_st_align #(
    .XLEN       (XLEN),
    .LINE_BYTES (LINE_BYTES)
  ) u_align (
    .i_offset   (w_offset),
    .i_size     (st_req_size_i),
    .i_data     (st_req_data_i),
    .o_data     (w_al_data),
    .o_mask     (w_al_mask),
    .o_misalign (w_mis)
  );

  assign st_req_rdy_o = (r_count < (PTR_W+1)'(DEPTH));
  assign w_acc        = st_req_vld_i & st_req_rdy_o;
  assign w_store      = w_acc & ~w_mis;
  assign w_deq        = l1d_st_vld_o & l1d_st_rdy_i;
  assign w_alloc      = w_store & ~w_hit;

`ifdef RVH_L1D_ST_MERGE_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0]     r_idle;
  logic [PTR_W-1:0]      w_young;
  logic                  w_young_open;
  logic                  w_merge;
  logic                  w_timeout;
  logic [DATA_W-1:0]     w_mrg_data;
  logic [LINE_BYTES-1:0] w_mrg_mask;

  // The youngest entry sits just behind the tail; only it may be open.
  assign w_young      = r_tail - PTR_W'(1);
  assign w_young_open = r_vld[w_young] & r_open[w_young];
  assign w_hit        = w_young_open & (r_line[w_young] == w_line_in);
  assign w_merge      = w_store & w_hit;
  assign w_timeout    = w_young_open & ~w_acc & (r_idle == IDLE_W'(TIMEOUT - 1));
  assign w_mrg_mask   = r_mask[w_young] | w_al_mask;
  assign w_alloc_open = ~(flush_i | (&w_al_mask));

  // Newer bytes overwrite older ones where the incoming mask is set.
  always_comb begin
    w_mrg_data = r_data[w_young];
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (w_al_mask[b]) begin
        w_mrg_data[b*8 +: 8] = w_al_data[b*8 +: 8];
      end
    end
  end
`else
  logic w_unused_flush;

  assign w_unused_flush = flush_i;
  assign w_hit          = 1'b0;
  assign w_alloc_open   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i]  <= 1'b0;
        r_open[i] <= 1'b0;
        r_line[i] <= '0;
        r_data[i] <= '0;
        r_mask[i] <= '0;
      end
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
`ifdef RVH_L1D_ST_MERGE_EN
      r_idle     <= '0;
`endif
    end else begin
      r_misalign <= w_acc & w_mis;

      if (w_deq) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PTR_W'(1);
      end

`ifdef RVH_L1D_ST_MERGE_EN
      // A different-line allocation closes whatever was youngest before it.
      if (w_alloc) begin
        r_open[w_young] <= 1'b0;
      end
`endif

      if (w_alloc) begin
        r_vld[r_tail]  <= 1'b1;
        r_open[r_tail] <= w_alloc_open;
        r_line[r_tail] <= w_line_in;
        r_data[r_tail] <= w_al_data;
        r_mask[r_tail] <= w_al_mask;
        r_tail         <= r_tail + PTR_W'(1);
      end

`ifdef RVH_L1D_ST_MERGE_EN
      if (w_merge) begin
        r_data[w_young] <= w_mrg_data;
        r_mask[w_young] <= w_mrg_mask;
        r_open[w_young] <= ~(flush_i | (&w_mrg_mask));
      end else if (!w_alloc && (flush_i || w_timeout)) begin
        r_open[w_young] <= 1'b0;
      end

      if (w_alloc || w_merge) begin
        r_idle <= '0;
      end else if (w_young_open && !w_acc) begin
        r_idle <= r_idle + IDLE_W'(1);
      end
`endif

      case ({w_alloc, w_deq})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign l1d_st_vld_o        = r_vld[r_head] & ~r_open[r_head];
  assign l1d_st_line_paddr_o = r_line[r_head];
  assign l1d_st_data_o       = r_data[r_head];
  assign l1d_st_byte_mask_o  = r_mask[r_head];
  assign misalign_err_o      = r_misalign;
  assign empty_o             = (r_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_rvh_l1d_st_merge_buf.sv
// ============================================================================
// Module   : tb_rvh_l1d_st_merge_buf
// Purpose  : Self-checking bench for rvh_l1d_st_merge_buf. A queue-based
//            reference model predicts buffer contents; entries that close are
//            pushed to a scoreboard and popped by a monitor on each L1D
//            handshake. Follows RVH_L1D_ST_MERGE_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rvh_l1d_st_merge_buf;

  localparam int XLEN  = 64;
  localparam int LB    = 64;
  localparam int OW    = 6;
  localparam int PW    = 56;
  localparam int LW    = PW - OW;
  localparam int DEPTH = 4;
  localparam int TO    = 16;
`ifdef RVH_L1D_ST_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            st_req_vld_i;
  logic            st_req_rdy_o;
  logic [PW-1:0]   st_req_paddr_i;
  logic [1:0]      st_req_size_i;
  logic [XLEN-1:0] st_req_data_i;
  logic            flush_i;
  logic            l1d_st_vld_o;
  logic            l1d_st_rdy_i;
  logic [LW-1:0]   l1d_st_line_paddr_o;
  logic [LB*8-1:0] l1d_st_data_o;
  logic [LB-1:0]   l1d_st_byte_mask_o;
  logic            misalign_err_o;
  logic            empty_o;

  always #5 clk = ~clk;

  rvh_l1d_st_merge_buf #(
    .XLEN(XLEN), .LINE_BYTES(LB), .PADDR_W(PW), .DEPTH(DEPTH), .TIMEOUT(TO)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .st_req_vld_i        (st_req_vld_i),
    .st_req_rdy_o        (st_req_rdy_o),
    .st_req_paddr_i      (st_req_paddr_i),
    .st_req_size_i       (st_req_size_i),
    .st_req_data_i       (st_req_data_i),
    .flush_i             (flush_i),
    .l1d_st_vld_o        (l1d_st_vld_o),
    .l1d_st_rdy_i        (l1d_st_rdy_i),
    .l1d_st_line_paddr_o (l1d_st_line_paddr_o),
    .l1d_st_data_o       (l1d_st_data_o),
    .l1d_st_byte_mask_o  (l1d_st_byte_mask_o),
    .misalign_err_o      (misalign_err_o),
    .empty_o             (empty_o)
  );

  typedef struct {
    logic [LW-1:0]   line;
    logic [LB*8-1:0] data;
    logic [LB-1:0]   mask;
    bit              open;
  } ent_t;

  ent_t mq[$];   // model buffer contents, oldest first
  ent_t sb[$];   // closed entries awaiting L1D handshake
  int   idle;
  bit   exp_mis;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [LB*8-1:0] act, input logic [LB*8-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: one clock edge worth of behaviour from the rules.
  task automatic model(input bit v, input logic [PW-1:0] pa, input logic [1:0] sz,
                       input logic [63:0] d, input bit fl, input bit rr);
    int cnt, nb, off, y;
    bit acc, deq, mis;
    logic [LW-1:0]   ln;
    logic [LB-1:0]   nm;
    logic [LB*8-1:0] nd;
    ent_t e;
    cnt = mq.size();
    acc = v && (cnt < DEPTH);
    deq = (cnt > 0) && !mq[0].open && rr;
    nb  = 1 << sz;
    off = int'(pa[OW-1:0]);
    ln  = pa[PW-1:OW];
    mis = ((off % nb) != 0) || (sz == 2'd3 && XLEN == 32);
    exp_mis = acc && mis;
    if (deq) void'(mq.pop_front());
    if (acc && !mis) begin
      nm = '0;
      nd = '0;
      for (int i = 0; i < nb; i++) begin
        nm[off+i] = 1'b1;
        nd[(off+i)*8 +: 8] = d[i*8 +: 8];
      end
      y = mq.size() - 1;
      if (MERGE && y >= 0 && mq[y].open && mq[y].line == ln) begin
        e = mq[y];
        for (int b = 0; b < LB; b++) if (nm[b]) e.data[b*8 +: 8] = nd[b*8 +: 8];
        e.mask = e.mask | nm;
        if (fl || (&e.mask)) begin
          e.open = 1'b0;
          sb.push_back(e);
        end
        mq[y] = e;
      end else begin
        if (y >= 0 && mq[y].open) begin
          mq[y].open = 1'b0;
          sb.push_back(mq[y]);
        end
        e.line = ln;
        e.data = nd;
        e.mask = nm;
        e.open = MERGE && !(fl || (&nm));
        if (!e.open) sb.push_back(e);
        mq.push_back(e);
      end
      idle = 0;
    end else begin
      y = mq.size() - 1;
      if (y >= 0 && mq[y].open) begin
        if (fl) begin
          mq[y].open = 1'b0;
          sb.push_back(mq[y]);
        end else if (!acc) begin
          idle++;
          if (idle == TO) begin
            mq[y].open = 1'b0;
            sb.push_back(mq[y]);
          end
        end
      end
    end
  endtask

  task automatic step(input bit v, input logic [PW-1:0] pa, input logic [1:0] sz,
                      input logic [63:0] d, input bit fl, input bit rr);
    st_req_vld_i   = v;
    st_req_paddr_i = pa;
    st_req_size_i  = sz;
    st_req_data_i  = d;
    flush_i        = fl;
    l1d_st_rdy_i   = rr;
    @(posedge clk);
    #1;
    model(v, pa, sz, d, fl, rr);
    chk("rdy_o",      st_req_rdy_o,   mq.size() < DEPTH);
    chk("empty_o",    empty_o,        mq.size() == 0);
    chk("l1d_vld_o",  l1d_st_vld_o,   (mq.size() > 0) && !mq[0].open);
    chk("misalign_o", misalign_err_o, exp_mis);
  endtask

  task automatic idle_cycles(input int n, input bit rr);
    for (int i = 0; i < n; i++) step(1'b0, '0, 2'd0, 64'h0, 1'b0, rr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    st_req_vld_i = 1'b0;
    flush_i = 1'b0;
    l1d_st_rdy_i = 1'b0;
    st_req_paddr_i = '0;
    st_req_size_i = '0;
    st_req_data_i = '0;
    @(posedge clk);
    #1;
    mq.delete();
    sb.delete();
    idle = 0;
    exp_mis = 1'b0;
    chk("rst_vld",   l1d_st_vld_o,        1'b0);
    chk("rst_empty", empty_o,             1'b1);
    chk("rst_rdy",   st_req_rdy_o,        1'b1);
    chk("rst_mis",   misalign_err_o,      1'b0);
    chk("rst_line",  l1d_st_line_paddr_o, '0);
    chk("rst_data",  l1d_st_data_o,       '0);
    chk("rst_mask",  l1d_st_byte_mask_o,  '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every L1D handshake must match the oldest closed model entry.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && l1d_st_vld_o && l1d_st_rdy_i) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL l1d_unexpected: got line %0h expected no entry", l1d_st_line_paddr_o);
        end else begin
          e = sb.pop_front();
          chk("l1d_line", l1d_st_line_paddr_o, e.line);
          chk("l1d_mask", l1d_st_byte_mask_o,  e.mask);
          chk("l1d_data", l1d_st_data_o,       e.data);
        end
      end
    end
  end

  initial begin
    int nb, off;
    logic [1:0] sz;
    logic [PW-1:0] pa;
    do_reset();

    // Single SD, drains after the idle timeout when merging is built.
    step(1'b1, 56'h1008, 2'd3, 64'h1122334455667788, 1'b0, 1'b1);
    idle_cycles(TO + 4, 1'b1);

    // Eight SDs filling line 0x80.
    for (int i = 0; i < 8; i++)
      step(1'b1, 56'h2000 + 56'(i*8), 2'd3, {$urandom, $urandom}, 1'b0, 1'b1);
    idle_cycles(3, 1'b1);

    // SB then overlapping SH, then flush.
    step(1'b1, 56'h2003, 2'd0, 64'hAA,   1'b0, 1'b1);
    step(1'b1, 56'h2002, 2'd1, 64'hBBCC, 1'b0, 1'b1);
    step(1'b0, '0, 2'd0, 64'h0, 1'b1, 1'b1);
    idle_cycles(3, 1'b1);

    // Misaligned SW is accepted and dropped.
    step(1'b1, 56'h3002, 2'd2, 64'hDEADBEEF, 1'b0, 1'b1);
    idle_cycles(2, 1'b1);

    // Fill with backpressure, one-cycle drain, then the fifth store lands.
    for (int i = 0; i < 5; i++)
      step(1'b1, 56'h10000 + 56'((i+1) << 6), 2'd3, 64'(i+1), 1'b0, 1'b0);
    step(1'b1, 56'h10000 + 56'(5 << 6), 2'd3, 64'h5, 1'b0, 1'b1);
    step(1'b1, 56'h10000 + 56'(5 << 6), 2'd3, 64'h5, 1'b0, 1'b0);
    step(1'b0, '0, 2'd0, 64'h0, 1'b1, 1'b1);
    idle_cycles(8, 1'b1);

    // Two SBs to one line, then the same with a reset mid-stream.
    step(1'b1, 56'h4000, 2'd0, 64'h11, 1'b0, 1'b1);
    step(1'b1, 56'h4001, 2'd0, 64'h22, 1'b0, 1'b1);
    step(1'b0, '0, 2'd0, 64'h0, 1'b1, 1'b1);
    idle_cycles(4, 1'b1);
    step(1'b1, 56'h4000, 2'd0, 64'h33, 1'b0, 1'b0);
    step(1'b1, 56'h4001, 2'd0, 64'h44, 1'b0, 1'b0);
    do_reset();
    idle_cycles(2, 1'b1);

    // Randomised traffic over a small pool of lines to exercise merging.
    for (int n = 0; n < 1500; n++) begin
      sz  = 2'($urandom_range(0, 3));
      nb  = 1 << sz;
      off = $urandom_range(0, LB - 1);
      if ($urandom_range(0, 9) != 0) off = off & ~(nb - 1);
      pa  = {LW'(32'h100 + $urandom_range(0, 2)), OW'(off)};
      step($urandom_range(0, 9) < 7, pa, sz, {$urandom, $urandom},
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
    end

    step(1'b0, '0, 2'd0, 64'h0, 1'b1, 1'b1);
    idle_cycles(DEPTH + 4, 1'b1);
    chk("sb_drained",    sb.size(), 0);
    chk("model_drained", mq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
